id_ex_stage: RTL

//  ID/EX pipeline register plus load-use hazard detection for the 5-stage MIPS core.

---
 rtl/id_ex_stage_if.sv | 45 ++++
 rtl/id_ex_stage.sv | 93 +++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Bundle between the ID stage, the ID/EX register and the EX consumers.
// The slave modport is the register's view; the master modport is the surrounding pipeline's view.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) ();
   logic              id_valid;
   logic [REG_W-1:0]  id_rs, id_rt, id_rd;
   logic              id_uses_rt;
   logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
   logic [1:0]        id_alu_op;
   logic              id_reg_write, id_mem_read, id_mem_write;
   logic              id_mem_to_reg, id_alu_src, id_reg_dst;
   logic              wb_reg_write;
   logic [REG_W-1:0]  wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              flush, ex_stall;

   logic              ex_valid;
   logic [REG_W-1:0]  ex_rs, ex_rt, ex_dest;
   logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [1:0]        ex_alu_op;
   logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
   logic              pc_write, if_id_write;
   logic [CNT_W-1:0]  hazard_count;

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rs_data, id_rt_data, id_imm,
             id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             id_alu_src, id_reg_dst, wb_reg_write, wb_rd, wb_data, flush, ex_stall,
      output ex_valid, ex_rs, ex_rt, ex_dest, ex_rs_data, ex_rt_data, ex_imm, ex_alu_op,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
             pc_write, if_id_write, hazard_count
   );

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rs_data, id_rt_data, id_imm,
             id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
             id_alu_src, id_reg_dst, wb_reg_write, wb_rd, wb_data, flush, ex_stall,
      input  ex_valid, ex_rs, ex_rt, ex_dest, ex_rs_data, ex_rt_data, ex_imm, ex_alu_op,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
             pc_write, if_id_write, hazard_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard interlock, WB-to-ID bypass,
// flush squash, downstream hold and a saturating bubble counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave bus
);
   // A bubble is exactly the all-zero value of this record.
   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  rs, rt, dest;
      logic [DATA_W-1:0] rs_data, rt_data, imm;
      logic [1:0]        alu_op;
      logic              reg_write, mem_read, mem_write, mem_to_reg, alu_src;
   } ex_regs_t;

   ex_regs_t         ex_q;
   ex_regs_t         id_fields;
   logic [CNT_W-1:0] count_q;
   logic             haz;

   assign haz = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && bus.id_valid &&
                ((ex_q.dest == bus.id_rs) || (bus.id_uses_rt && (ex_q.dest == bus.id_rt)));

   always_comb begin
      // NOTE: assign every field a default before any condition so no latch is inferred.
      id_fields            = '0;
      id_fields.valid      = bus.id_valid;
      id_fields.rs         = bus.id_rs;
      id_fields.rt         = bus.id_rt;
      id_fields.dest       = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      id_fields.rs_data    = bus.id_rs_data;
      id_fields.rt_data    = bus.id_rt_data;
      id_fields.imm        = bus.id_imm;
      id_fields.alu_op     = bus.id_alu_op;
      id_fields.reg_write  = bus.id_reg_write;
      id_fields.mem_read   = bus.id_mem_read;
      id_fields.mem_write  = bus.id_mem_write;
      id_fields.mem_to_reg = bus.id_mem_to_reg;
      id_fields.alu_src    = bus.id_alu_src;
      // Register file writes in WB are not yet visible to ID reads in the same cycle.
      if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs))
         id_fields.rs_data = bus.wb_data;
      if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rt))
         id_fields.rt_data = bus.wb_data;
   end

   always_comb begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      if (rst && (bus.flush || !(bus.ex_stall || haz))) begin
         bus.pc_write    = 1'b1;
         bus.if_id_write = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!rst) begin
         ex_q    <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         ex_q <= '0;
      end else if (bus.ex_stall) begin
         ex_q <= ex_q;
      end else if (haz) begin
         ex_q <= '0;
         if (count_q != '1)
            count_q <= count_q + CNT_W'(1);
      end else begin
         ex_q <= id_fields;
      end
   end

   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_rs         = ex_q.rs;
   assign bus.ex_rt         = ex_q.rt;
   assign bus.ex_dest       = ex_q.dest;
   assign bus.ex_rs_data    = ex_q.rs_data;
   assign bus.ex_rt_data    = ex_q.rt_data;
   assign bus.ex_imm        = ex_q.imm;
   assign bus.ex_alu_op     = ex_q.alu_op;
   assign bus.ex_reg_write  = ex_q.reg_write;
   assign bus.ex_mem_read   = ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.mem_write;
   assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
   assign bus.ex_alu_src    = ex_q.alu_src;
   assign bus.hazard_count  = count_q;
endmodule
